// File: rtl/cpu_wb_wide_add_seq.sv
// Wide add/subtract sequencer: arbitrates two requesters onto one shared
// DATA_WID-bit adder and chains the carry word by word, LSW first.

module cpu_wb_wide_add_seq #(
  parameter int DATA_WID  = 32,
  parameter int NUM_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [NUM_WORDS*DATA_WID-1:0] req0_a,
  input  logic [NUM_WORDS*DATA_WID-1:0] req0_b,
  input  logic                          req0_sub,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [NUM_WORDS*DATA_WID-1:0] req1_a,
  input  logic [NUM_WORDS*DATA_WID-1:0] req1_b,
  input  logic                          req1_sub,
  output logic [DATA_WID-1:0]           add_in1,
  output logic [DATA_WID-1:0]           add_in2,
  output logic                          add_cin,
  input  logic [DATA_WID-1:0]           add_sum,
  input  logic                          add_cout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_WORDS*DATA_WID-1:0] rsp_sum,
  output logic                          rsp_cout,
  output logic                          rsp_id
);

  localparam int W     = NUM_WORDS * DATA_WID;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               ptr_r;
  logic [W-1:0]       op_a_r;
  logic [W-1:0]       op_b_r;
  logic               sub_r;
  logic               id_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [W-1:0]       sum_r;
  logic               cout_r;
  logic               accept_s;
  logic               grant_s;
  logic [DATA_WID-1:0] word_a_s;
  logic [DATA_WID-1:0] word_b_s;

  // Arbitration and next-state: ptr_r names the favoured port on a tie.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    grant_s    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst) begin
          accept_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
          accept_s = 1'b1;
          grant_s  = ptr_r;
        end else if (req0_valid) begin
          accept_s = 1'b1;
          grant_s  = 1'b0;
        end else if (req1_valid) begin
          accept_s = 1'b1;
          grant_s  = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
        req0_ready = accept_s && !grant_s;
        req1_ready = accept_s && grant_s;
        if (accept_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign word_a_s = op_a_r[int'(idx_r)*DATA_WID +: DATA_WID];
  assign word_b_s = op_b_r[int'(idx_r)*DATA_WID +: DATA_WID];

  // Shared adder drive; subtraction is a + ~b with carry-in 1 on the LSW.
  always_comb begin
    add_in1 = {DATA_WID{1'b0}};
    add_in2 = {DATA_WID{1'b0}};
    add_cin = 1'b0;
    if ((state_r == RUN) && !rst) begin
      add_in1 = word_a_s;
      add_in2 = sub_r ? ~word_b_s : word_b_s;
      add_cin = (idx_r == {IDX_W{1'b0}}) ? sub_r : carry_r;
    end else begin
      add_in1 = {DATA_WID{1'b0}};
      add_in2 = {DATA_WID{1'b0}};
      add_cin = 1'b0;
    end
  end

  // Operand capture, per-word result/carry accumulation and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 1'b0;
      op_a_r  <= {W{1'b0}};
      op_b_r  <= {W{1'b0}};
      sub_r   <= 1'b0;
      id_r    <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r   <= grant_s;
            op_a_r <= grant_s ? req1_a : req0_a;
            op_b_r <= grant_s ? req1_b : req0_b;
            sub_r  <= grant_s ? req1_sub : req0_sub;
            idx_r  <= {IDX_W{1'b0}};
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*DATA_WID +: DATA_WID] <= add_sum;
          carry_r <= add_cout;
          if (idx_r == LAST_IDX) begin
            cout_r <= add_cout;
            idx_r  <= {IDX_W{1'b0}};
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            ptr_r <= ~id_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_r == DONE) && !rst;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;
  assign rsp_id    = id_r;

  cpu_wb_wide_add_seq_chk #(
    .DATA_WID (DATA_WID),
    .W        (W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .busy       (state_r != IDLE),
    .run        (state_r == RUN),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .add_in1    (add_in1),
    .add_in2    (add_in2),
    .add_cin    (add_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

endmodule

// Protocol checks for the sequencer's handshakes and adder port.
module cpu_wb_wide_add_seq_chk #(
  parameter int DATA_WID = 32,
  parameter int W        = 128
) (
  input logic                clk,
  input logic                rst,
  input logic                busy,
  input logic                run,
  input logic                req0_valid,
  input logic                req0_ready,
  input logic                req1_valid,
  input logic                req1_ready,
  input logic [DATA_WID-1:0] add_in1,
  input logic [DATA_WID-1:0] add_in2,
  input logic                add_cin,
  input logic                rsp_valid,
  input logic                rsp_ready,
  input logic [W-1:0]        rsp_sum,
  input logic                rsp_cout,
  input logic                rsp_id
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
    !(req0_ready && req1_ready));

  a_ready_has_valid: assert property (@(posedge clk) disable iff (rst)
    (!req0_ready || req0_valid) && (!req1_ready || req1_valid));

  a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
    busy |-> (!req0_ready && !req1_ready));

  a_adder_quiet: assert property (@(posedge clk) disable iff (rst)
    !run |-> ((add_in1 == {DATA_WID{1'b0}}) && (add_in2 == {DATA_WID{1'b0}}) && !add_cin));

  a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_sum) && $stable(rsp_cout) && $stable(rsp_id)));

endmodule

// File: tb/tb_cpu_wb_wide_add_seq.sv
// Bench for cpu_wb_wide_add_seq: directed and random traffic, with a
// scoreboard monitor comparing each response to an arithmetic reference.

module tb_cpu_wb_wide_add_seq;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  logic          clk, rst;
  logic          req0_valid, req0_ready, req0_sub;
  logic          req1_valid, req1_ready, req1_sub;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] add_in1, add_in2, add_sum;
  logic          add_cin, add_cout;
  logic          rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0]  rsp_sum;
  logic [DW:0]   add_res;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  sum;
    logic          cout;
    logic          id;
    logic [NW-1:0] cin;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, hs_cyc = 0, n_rsp = 0, kk;
  bit   inflight = 1'b0, rsp_seen = 1'b0, ptr_m = 1'b0, rst_prev = 1'b0;
  logic exp0, exp1;
  logic [W-1:0] last_sum;
  logic last_cout, last_id;

  cpu_wb_wide_add_seq #(.DATA_WID(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  // External adder the block time-shares.
  assign add_res  = {1'b0, add_in1} + {1'b0, add_in2} + {{DW{1'b0}}, add_cin};
  assign add_sum  = add_res[DW-1:0];
  assign add_cout = add_res[DW];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input bit ok, input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Reference: full-width arithmetic, plus the carry that enters each word.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic id);
    exp_t e;
    logic [W:0] s, mask, alo, blo;
    e.a  = a;
    e.id = id;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
    end else begin
      s      = {1'b0, a} + {1'b0, b};
      e.sum  = s[W-1:0];
      e.cout = s[W];
    end
    e.cin[0] = sub;
    for (int k = 1; k < NW; k++) begin
      mask = ({{W{1'b0}}, 1'b1} << (DW * k)) - {{W{1'b0}}, 1'b1};
      alo  = {1'b0, a} & mask;
      blo  = {1'b0, b} & mask;
      if (sub) e.cin[k] = (alo >= blo);
      else     e.cin[k] = (((alo + blo) >> (DW * k)) != {(W+1){1'b0}});
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return {W{1'b1}};
      1:       return {W{1'b0}};
      2:       return {$urandom(), $urandom(), $urandom(), $urandom()};
      default: return W'($urandom_range(0, 7));
    endcase
  endfunction

  // Scoreboard monitor: grant model, adder port sequence, response checks.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      chk(!req0_ready && !req1_ready, "rst_ready", W'({req1_ready, req0_ready}), '0);
      chk(!rsp_valid, "rst_rsp_valid", W'(rsp_valid), '0);
      chk(add_in1 == '0 && add_in2 == '0 && !add_cin, "rst_adder", W'({add_cin, add_in1, add_in2}), '0);
      if (rst_prev) chk(rsp_sum == '0 && !rsp_cout && !rsp_id, "rst_rsp_regs", rsp_sum ^ W'({rsp_cout, rsp_id}), '0);
      exp_q.delete();
      inflight = 1'b0;
      ptr_m    = 1'b0;
    end else begin
      if (inflight) begin
        exp0 = 1'b0; exp1 = 1'b0;
      end else if (req0_valid && req1_valid) begin
        exp0 = !ptr_m; exp1 = ptr_m;
      end else begin
        exp0 = req0_valid; exp1 = req1_valid;
      end
      chk(req0_ready == exp0 && req1_ready == exp1, "grant", W'({req1_ready, req0_ready}), W'({exp1, exp0}));
      if (!inflight && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
        if (req1_valid && req1_ready) e_mon = ref_model(req1_a, req1_b, req1_sub, 1'b1);
        else                          e_mon = ref_model(req0_a, req0_b, req0_sub, 1'b0);
        exp_q.push_back(e_mon);
        inflight = 1'b1;
        rsp_seen = 1'b0;
        acc_cyc  = cyc;
      end else if (inflight && exp_q.size() > 0) begin
        kk    = cyc - acc_cyc - 1;
        e_mon = exp_q[0];
        if (kk >= 0 && kk < NW) begin
          chk(add_cin == e_mon.cin[kk], "add_cin", W'(add_cin), W'(e_mon.cin[kk]));
          chk(add_in1 == e_mon.a[kk*DW +: DW], "add_in1", W'(add_in1), W'(e_mon.a[kk*DW +: DW]));
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_rsp", W'(rsp_valid), '0);
        end else begin
          e_mon = exp_q[0];
          if (!rsp_seen) begin
            chk(cyc - acc_cyc == NW + 1, "latency", W'(cyc - acc_cyc), W'(NW + 1));
            rsp_seen = 1'b1;
          end
          chk(rsp_sum == e_mon.sum, "rsp_sum", rsp_sum, e_mon.sum);
          chk(rsp_cout == e_mon.cout, "rsp_cout", W'(rsp_cout), W'(e_mon.cout));
          chk(rsp_id == e_mon.id, "rsp_id", W'(rsp_id), W'(e_mon.id));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            inflight  = 1'b0;
            ptr_m     = !e_mon.id;
            hs_cyc    = cyc;
            n_rsp     = n_rsp + 1;
            last_sum  = rsp_sum;
            last_cout = rsp_cout;
            last_id   = rsp_id;
          end
        end
      end else if (inflight && (cyc - acc_cyc >= NW + 1)) begin
        chk(1'b0, "rsp_valid_missing", W'(rsp_valid), W'(1'b1));
      end
    end
    rst_prev = rst;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit port, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, output int waited);
    if (port) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1; end
    waited = 0;
    forever begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) break;
      waited++;
      if (waited > 100) begin
        chk(1'b0, "accept_timeout", W'(waited), '0);
        break;
      end
    end
    cycle();
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300; t++) begin
      if (!inflight) return;
      cycle();
    end
    chk(1'b0, "idle_timeout", W'(inflight), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited, ng, nr, t;
    logic g0, g1;
    logic grants [8];
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_sub = 1'b0; req1_sub = 1'b0;

    // Reset with random inputs toggling.
    repeat (3) begin
      cycle();
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
      req0_sub = 1'($urandom_range(0, 1)); req1_sub = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
    end
    cycle();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    cycle();

    // Full carry ripple through every word.
    send(1'b0, {W{1'b1}}, W'(1), 1'b0, waited);
    wait_idle();
    chk(last_sum == '0, "ripple_sum", last_sum, '0);
    chk(last_cout == 1'b1, "ripple_cout", W'(last_cout), W'(1));
    chk(last_id == 1'b0, "ripple_id", W'(last_id), '0);

    // Subtractions with and without borrow.
    send(1'b1, '0, W'(1), 1'b1, waited);
    wait_idle();
    chk(last_sum == {W{1'b1}}, "sub_borrow_sum", last_sum, {W{1'b1}});
    chk(last_cout == 1'b0, "sub_borrow_cout", W'(last_cout), '0);
    send(1'b1, W'(5), W'(3), 1'b1, waited);
    wait_idle();
    chk(last_sum == W'(2), "sub_small_sum", last_sum, W'(2));
    chk(last_cout == 1'b1, "sub_small_cout", W'(last_cout), W'(1));

    // Arbitration: both ports valid continuously after reset.
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = 1'($urandom_range(0, 1));
    req1_a = rnd_op(); req1_b = rnd_op(); req1_sub = 1'($urandom_range(0, 1));
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      cycle();
      if (g0) begin grants[ng] = 1'b0; ng++; req0_a = rnd_op(); req0_b = rnd_op(); end
      if (g1) begin grants[ng] = 1'b1; ng++; req1_a = rnd_op(); req1_b = rnd_op(); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk(ng == 4, "arb_grant_count", W'(ng), W'(4));
    for (int i = 0; i < ng; i++) chk(grants[i] == 1'(i % 2), "arb_order", W'(grants[i]), W'(i % 2));
    wait_idle();

    // Only port 1 pending while the pointer favours port 0.
    send(1'b1, rnd_op(), rnd_op(), 1'b0, waited);
    chk(waited == 0, "port1_immediate", W'(waited), '0);
    wait_idle();
    chk(last_id == 1'b1, "port1_id", W'(last_id), W'(1));

    // Backpressure with a new request waiting on port 0.
    rsp_ready = 1'b0;
    send(1'b0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), waited);
    req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = 1'($urandom_range(0, 1)); req0_valid = 1'b1;
    t = 0;
    while (!rsp_valid && t < 50) begin cycle(); t++; end
    chk(rsp_valid == 1'b1, "bp_reached_done", W'(rsp_valid), W'(1));
    repeat (10) cycle();
    rsp_ready = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (req0_ready || t > 50) break;
      t++;
    end
    cycle();
    req0_valid = 1'b0;
    chk(acc_cyc - hs_cyc == 1, "bp_accept_after_hs", W'(acc_cyc - hs_cyc), W'(1));
    wait_idle();

    // Reset in the second RUN cycle aborts; next request taken right after.
    nr = n_rsp;
    send(1'b0, rnd_op(), rnd_op(), 1'b0, waited);
    cycle();
    rst = 1'b1;
    req1_a = rnd_op(); req1_b = rnd_op(); req1_sub = 1'($urandom_range(0, 1)); req1_valid = 1'b1;
    cycle();
    rst = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (req1_ready || t > 50) break;
      t++;
    end
    cycle();
    req1_valid = 1'b0;
    chk(t == 0, "post_rst_accept", W'(t), '0);
    wait_idle();
    chk(n_rsp - nr == 1, "aborted_no_rsp", W'(n_rsp - nr), W'(1));
    chk(last_id == 1'b1, "post_rst_id", W'(last_id), W'(1));

    // Random traffic with random backpressure and withdrawn requests.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      cycle();
      if (g0) req0_valid = 1'b0;
      else if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(0, 3) == 0) begin
        req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = 1'($urandom_range(0, 1)); req0_valid = 1'b1;
      end
      if (g1) req1_valid = 1'b0;
      else if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(0, 3) == 0) begin
        req1_a = rnd_op(); req1_b = rnd_op(); req1_sub = 1'($urandom_range(0, 1)); req1_valid = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    cycle();
    wait_idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_wb_wide_add_seq.md
# cpu_wb_wide_add_seq

Multi-cycle wide-operand add/subtract sequencer that time-shares one external DATA_WID-bit carry-lookahead adder between two requesters. It sits in the write-back stage beside the adder instance. It arbitrates round-robin between two request ports, then feeds the adder one word per cycle from least-significant word upward, chaining the carry through a register. The NUM_WORDS×DATA_WID-bit result is returned on a single valid/ready response channel.

## Interface
- DATA_WID, 32, width of the shared adder (one word)
- NUM_WORDS, 4, words per operand (≥2); operand width W = NUM_WORDS×DATA_WID
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  W  operands, held stable while valid && !ready
- req0_sub / req1_sub  in  1  1 = a − b, 0 = a + b
- add_in1, add_in2  out  DATA_WID  to adder in1/in2
- add_cin  out  1  to adder carry_in
- add_sum  in  DATA_WID  from adder sum (combinational, same cycle)
- add_cout  in  1  from adder carry_out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  W  result
- rsp_cout  out  1  final carry (subtract: 1 = no borrow)
- rsp_id  out  1  port that issued the request

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If any reqN_valid, grant one port. If both are valid, grant the port not granted last; a priority pointer tracks this.
  - Assert that port's reqN_ready for this cycle only.
  - Latch a, b, sub, and id. Set idx = 0. Go to RUN.
  - reqN_ready is high only in IDLE, for the granted port, with its valid high. ready may depend combinationally on valid.
- RUN, each cycle:
  - add_in1 = a[idx]; add_in2 = sub ? ~b[idx] : b[idx].
  - add_cin = (idx==0) ? sub : carry_q.
  - Register rsp_sum[idx] <= add_sum and carry_q <= add_cout.
  - If idx == NUM_WORDS−1, set rsp_cout <= add_cout and go to DONE. Otherwise idx++.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout, and rsp_id are stable.
  - On rsp_ready, go to IDLE and set the pointer to favour the other port.
- Outside RUN, add_in1, add_in2, and add_cin drive 0.
- Arithmetic is modulo 2^W. The carry is never truncated between words.
- A requester may drop valid before it is granted; the request is then ignored.
- No new request is accepted while in RUN or DONE.

## Timing
- Reset values:
  - State IDLE; pointer favours port 0.
  - rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, carry_q 0, idx 0.
  - req*_ready 0; add_* 0.
- Reset applied in RUN or DONE aborts the operation. No response is issued, and the block is in IDLE the cycle after rst deasserts.
- Latency: accept handshake at cycle T; adder in use T+1 … T+NUM_WORDS; rsp_valid first high at T+NUM_WORDS+1.
- Back-to-back minimum issue interval is NUM_WORDS+2 cycles (IDLE + RUN + one DONE cycle).
- Under rsp_ready = 0, DONE holds indefinitely. Outputs stay stable and req*_ready stays 0.
- The adder path is combinational within a cycle: add_* → add_sum/add_cout → result and carry registers.

## Test plan
- Reset/idle: hold rst 3 cycles with random inputs. Required: all outputs 0, state IDLE; no ready, no rsp_valid.
- Full carry ripple (NUM_WORDS=4):
  - Port 0, a = 2^128−1, b = 1, sub = 0.
  - Required: rsp_sum = 0, rsp_cout = 1, rsp_id = 0.
  - rsp_valid exactly 5 cycles after the accept cycle. add_cin sequence 0,1,1,1.
- Subtract:
  - Port 1, a = 0, b = 1, sub = 1. Required: rsp_sum = 2^128−1, rsp_cout = 0.
  - Then a = 5, b = 3, sub = 1. Required: rsp_sum = 2, rsp_cout = 1.
- Arbitration:
  - After reset, both valid continuously with distinct operands. Required grants alternate 0,1,0,1 with matching rsp_id and correct sums.
  - Only port 1 valid. Required: granted immediately despite the pointer.
- Backpressure: rsp_ready low 10 cycles in DONE while req0_valid is high. Required: rsp_* stable, req0_ready 0 throughout; accept occurs the cycle after the rsp handshake.
- Reset mid-operation: assert rst at the 2nd RUN cycle. Required: rsp_valid never asserts for that request, and a new request is accepted the first cycle after rst falls.
